// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared encodings for the 32-bit ALU and the logic that drives it:
//   - 4-bit ALU control codes consumed by the ALU's ctrl input
//   - 3-bit ALUOp values produced by the main control unit
//   - 6-bit R-type funct values (instr[5:0]) that the ALU understands
//   Imported by alu_ctrl_dec, alu_issue_stage and the ALU itself.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU control codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // ALUOp from main control
   localparam logic [2:0] ALUOP_ADD   = 3'b000;  // loads/stores/addi
   localparam logic [2:0] ALUOP_SUB   = 3'b001;  // branch compare
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;  // look at funct
   localparam logic [2:0] ALUOP_OR    = 3'b011;  // ori
   localparam logic [2:0] ALUOP_SLT   = 3'b100;  // slti

   // R-type funct field
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage : alu_pkg

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
//   Purely combinational ALU control decoder: maps ALUOp (and funct for
//   R-type) onto the ALU's 4-bit ctrl code. Undefined combinations fall back
//   to ADD so the ALU never sees an unknown code, and raise o_illegal.
// Ports
//   i_aluop    in   3   ALUOp from main control
//   i_funct    in   6   instr[5:0]
//   o_ctrl     out  4   ALU ctrl code
//   o_illegal  out  1   ALUOp/funct combination is undefined
// -----------------------------------------------------------------------------
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [2:0] i_aluop,
   input  logic [5:0] i_funct,
   output logic [3:0] o_ctrl,
   output logic       o_illegal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      o_ctrl    = ALU_ADD;
      o_illegal = 1'b0;
      case (i_aluop)
         ALUOP_ADD: o_ctrl = ALU_ADD;
         ALUOP_SUB: o_ctrl = ALU_SUB;
         ALUOP_OR:  o_ctrl = ALU_OR;
         ALUOP_SLT: o_ctrl = ALU_SLT;
         ALUOP_RTYPE: begin
            case (i_funct)
               FUNCT_ADD: o_ctrl = ALU_ADD;
               FUNCT_SUB: o_ctrl = ALU_SUB;
               FUNCT_AND: o_ctrl = ALU_AND;
               FUNCT_OR:  o_ctrl = ALU_OR;
               FUNCT_SLT: o_ctrl = ALU_SLT;
               default:   o_illegal = 1'b1;
            endcase
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule : alu_ctrl_dec

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   ID/EX + EX/MEM pipeline slice around the external 32-bit ALU.
//   ISSUE register holds a decoded instruction; its operands (with EX/WB
//   forwarding) and decoded ctrl drive the ALU combinationally. RESULT register
//   captures the ALU result/zero plus rd/regwrite. Both registers have a valid
//   bit and handshake with valid/ready; throughput is one instruction per cycle.
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   id_*                          decode-stage instruction + valid/ready
//   flush_i                       kill instruction held in ISSUE
//   wb_regwrite_i/wb_rd_i/wb_data_i  writeback-stage forwarding source
//   alu_src1_o/alu_src2_o/alu_ctrl_o to ALU; alu_result_i/alu_zero_i from ALU
//   ex_*                          registered result towards memory stage
//   illegal_o                     sticky undefined-op flag
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          id_valid_i,
   output logic          id_ready_o,
   input  logic [2:0]    id_aluop_i,
   input  logic [5:0]    id_funct_i,
   input  logic          id_alusrc_i,
   input  logic          id_regwrite_i,
   input  logic [RW-1:0] id_rs_i,
   input  logic [RW-1:0] id_rt_i,
   input  logic [RW-1:0] id_rd_i,
   input  logic [DW-1:0] id_rs_data_i,
   input  logic [DW-1:0] id_rt_data_i,
   input  logic [DW-1:0] id_imm_i,
   input  logic          flush_i,
   input  logic          wb_regwrite_i,
   input  logic [RW-1:0] wb_rd_i,
   input  logic [DW-1:0] wb_data_i,
   output logic [DW-1:0] alu_src1_o,
   output logic [DW-1:0] alu_src2_o,
   output logic [3:0]    alu_ctrl_o,
   input  logic [DW-1:0] alu_result_i,
   input  logic          alu_zero_i,
   output logic          ex_valid_o,
   input  logic          ex_ready_i,
   output logic [DW-1:0] ex_result_o,
   output logic          ex_zero_o,
   output logic [RW-1:0] ex_rd_o,
   output logic          ex_regwrite_o,
   output logic          illegal_o
);

   typedef struct packed {
      logic [2:0]    aluop;
      logic [5:0]    funct;
      logic          alusrc;
      logic          regwrite;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
   } issue_t;

   issue_t        r_iss;
   logic          r_iss_valid;
   logic          r_ex_valid;
   logic [DW-1:0] r_ex_result;
   logic          r_ex_zero;
   logic [RW-1:0] r_ex_rd;
   logic          r_ex_regwrite;
   logic          r_illegal;

   issue_t        w_id_pkt;
   logic          w_advance;
   logic          w_accept;
   logic [3:0]    w_ctrl;
   logic          w_dec_illegal;
   logic          w_rs_ex_hit, w_rs_wb_hit;
   logic          w_rt_ex_hit, w_rt_wb_hit;
   logic [DW-1:0] w_rs_fwd, w_rt_fwd;

   // Handshake: ISSUE drains into RESULT whenever RESULT is empty or being taken.
   assign w_advance  = r_iss_valid & (~r_ex_valid | ex_ready_i);
   assign id_ready_o = ~r_iss_valid | w_advance;
   assign w_accept   = id_valid_i & id_ready_o;

   assign w_id_pkt = '{aluop:    id_aluop_i,
                       funct:    id_funct_i,
                       alusrc:   id_alusrc_i,
                       regwrite: id_regwrite_i,
                       rs:       id_rs_i,
                       rt:       id_rt_i,
                       rd:       id_rd_i,
                       rs_data:  id_rs_data_i,
                       rt_data:  id_rt_data_i,
                       imm:      id_imm_i};

   // ISSUE (ID/EX) register. A flush only kills the held instruction; a new
   // accept in the same cycle still loads.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst_i) begin
         r_iss_valid <= 1'b0;
         r_iss       <= '0;
      end else if (w_accept) begin
         r_iss_valid <= 1'b1;
         r_iss       <= w_id_pkt;
      end else if (flush_i | w_advance) begin
         r_iss_valid <= 1'b0;
      end
   end

   alu_ctrl_dec u_ctrl_dec (
      .i_aluop   (r_iss.aluop),
      .i_funct   (r_iss.funct),
      .o_ctrl    (w_ctrl),
      .o_illegal (w_dec_illegal)
   );

   // Forwarding: EX result beats WB data; register 0 is hard-wired and never
   // forwarded.
   assign w_rs_ex_hit = (r_iss.rs != '0) & r_ex_valid & r_ex_regwrite & (r_ex_rd == r_iss.rs);
   assign w_rs_wb_hit = (r_iss.rs != '0) & wb_regwrite_i & (wb_rd_i == r_iss.rs);
   assign w_rt_ex_hit = (r_iss.rt != '0) & r_ex_valid & r_ex_regwrite & (r_ex_rd == r_iss.rt);
   assign w_rt_wb_hit = (r_iss.rt != '0) & wb_regwrite_i & (wb_rd_i == r_iss.rt);

   assign w_rs_fwd = w_rs_ex_hit ? r_ex_result :
                     w_rs_wb_hit ? wb_data_i   : r_iss.rs_data;
   assign w_rt_fwd = w_rt_ex_hit ? r_ex_result :
                     w_rt_wb_hit ? wb_data_i   : r_iss.rt_data;

   assign alu_src1_o = w_rs_fwd;
   assign alu_src2_o = r_iss.alusrc ? r_iss.imm : w_rt_fwd;
   assign alu_ctrl_o = w_ctrl;

   // RESULT (EX/MEM) register plus sticky illegal flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ex_valid    <= 1'b0;
         r_ex_result   <= '0;
         r_ex_zero     <= 1'b0;
         r_ex_rd       <= '0;
         r_ex_regwrite <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         if (w_advance) begin
            r_ex_valid    <= 1'b1;
            r_ex_result   <= alu_result_i;
            r_ex_zero     <= alu_zero_i;
            r_ex_rd       <= r_iss.rd;
            r_ex_regwrite <= r_iss.regwrite;
         end else if (ex_ready_i) begin
            r_ex_valid <= 1'b0;
         end
         if (w_advance & w_dec_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign ex_valid_o    = r_ex_valid;
   assign ex_result_o   = r_ex_result;
   assign ex_zero_o     = r_ex_zero;
   assign ex_rd_o       = r_ex_rd;
   assign ex_regwrite_o = r_ex_regwrite;
   assign illegal_o     = r_illegal;

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed vectors with hand-computed results. Each issued instruction pushes
//   its expected output into a scoreboard queue; a monitor pops and compares on
//   every EX handshake. A small behavioural ALU closes the alu_* loop.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        id_valid, id_ready;
   logic [2:0]  id_aluop;
   logic [5:0]  id_funct;
   logic        id_alusrc, id_regwrite;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        flush;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic [3:0]  alu_ctrl;
   logic        alu_zero;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_result;
   logic        ex_zero;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        illegal;

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic [4:0]  rd;
      logic        regwrite;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_issue_stage #(.DW(32), .RW(5)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_valid_i    (id_valid),
      .id_ready_o    (id_ready),
      .id_aluop_i    (id_aluop),
      .id_funct_i    (id_funct),
      .id_alusrc_i   (id_alusrc),
      .id_regwrite_i (id_regwrite),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_rd_i       (id_rd),
      .id_rs_data_i  (id_rs_data),
      .id_rt_data_i  (id_rt_data),
      .id_imm_i      (id_imm),
      .flush_i       (flush),
      .wb_regwrite_i (wb_regwrite),
      .wb_rd_i       (wb_rd),
      .wb_data_i     (wb_data),
      .alu_src1_o    (alu_src1),
      .alu_src2_o    (alu_src2),
      .alu_ctrl_o    (alu_ctrl),
      .alu_result_i  (alu_result),
      .alu_zero_i    (alu_zero),
      .ex_valid_o    (ex_valid),
      .ex_ready_i    (ex_ready),
      .ex_result_o   (ex_result),
      .ex_zero_o     (ex_zero),
      .ex_rd_o       (ex_rd),
      .ex_regwrite_o (ex_regwrite),
      .illegal_o     (illegal)
   );

   // Behavioural ALU
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_src1 & alu_src2;
         4'b0001: alu_result = alu_src1 | alu_src2;
         4'b0010: alu_result = alu_src1 + alu_src2;
         4'b0110: alu_result = alu_src1 - alu_src2;
         4'b0111: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: one pop per EX handshake.
   always @(negedge clk) begin
      if (!rst && ex_valid && ex_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out_unexpected: got rd %0d result 0x%08h expected no output", ex_rd, ex_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_result",   ex_result,          e.result);
            check("out_zero",     {31'd0, ex_zero},   {31'd0, e.zero});
            check("out_rd",       {27'd0, ex_rd},     {27'd0, e.rd});
            check("out_regwrite", {31'd0, ex_regwrite}, {31'd0, e.regwrite});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one instruction and wait for it to be accepted; returns 1 time
   // unit after the accepting edge with the instruction in the issue register.
   task automatic send(input logic [2:0] aluop, input logic [5:0] funct,
                       input logic alusrc, input logic regwrite,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rs_data, input logic [31:0] rt_data,
                       input logic [31:0] imm, input logic [31:0] exp_res, input bit push);
      bit   ok;
      exp_t e;
      id_aluop    = aluop;
      id_funct    = funct;
      id_alusrc   = alusrc;
      id_regwrite = regwrite;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_rs_data  = rs_data;
      id_rt_data  = rt_data;
      id_imm      = imm;
      id_valid    = 1'b1;
      if (push) begin
         e.result   = exp_res;
         e.zero     = (exp_res == 32'd0);
         e.rd       = rd;
         e.regwrite = regwrite;
         sb.push_back(e);
      end
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (id_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got id_ready 0 for 50 cycles expected acceptance");
      end
      @(posedge clk);
      #1;
      id_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; id_valid = 0; id_aluop = 0; id_funct = 0; id_alusrc = 0;
      id_regwrite = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0;
      id_rt_data = 0; id_imm = 0; flush = 0; wb_regwrite = 0; wb_rd = 0;
      wb_data = 0; ex_ready = 1;

      // Reset state
      tick(2);
      check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_illegal",  {31'd0, illegal},  32'd0);
      check("rst_id_ready", {31'd0, id_ready}, 32'd1);
      check("rst_ex_result", ex_result, 32'd0);
      rst = 1'b0;
      tick(1);

      // R-type sub 7-9, two-cycle latency
      send(3'b010, 6'b100010, 0, 1, 5'd1, 5'd2, 5'd2, 32'd7, 32'd9, 32'd0, 32'hFFFF_FFFE, 1);
      check("sub_ctrl", {28'd0, alu_ctrl}, 32'h6);
      check("sub_not_yet_valid", {31'd0, ex_valid}, 32'd0);
      tick(1);
      check("sub_valid", {31'd0, ex_valid}, 32'd1);
      check("sub_result", ex_result, 32'hFFFF_FFFE);
      check("sub_zero", {31'd0, ex_zero}, 32'd0);
      tick(2);

      // Plain ALUOp codes, back to back
      send(3'b001, 6'b000000, 0, 0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'd0, 32'd0, 1);
      check("aluop_sub_ctrl", {28'd0, alu_ctrl}, 32'h6);
      send(3'b011, 6'b000000, 1, 1, 5'd1, 5'd2, 5'd5, 32'h0000_00F0, 32'd0, 32'h0000_000F, 32'h0000_00FF, 1);
      check("aluop_or_ctrl", {28'd0, alu_ctrl}, 32'h1);
      send(3'b100, 6'b000000, 1, 1, 5'd1, 5'd2, 5'd6, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd1, 1);
      check("aluop_slt_ctrl", {28'd0, alu_ctrl}, 32'h7);
      tick(3);

      // Forwarding chain
      send(3'b010, 6'b100000, 0, 1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 32'd30, 1);
      send(3'b010, 6'b100101, 0, 1, 5'd3, 5'd5, 5'd4, 32'd0, 32'd5, 32'd0, 32'd31, 1);
      check("fwd_ex_src1", alu_src1, 32'd30);
      check("fwd_or_ctrl", {28'd0, alu_ctrl}, 32'h1);
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd3, 32'd10, 32'd0, 32'd30, 32'd40, 1);
      wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'd100;
      send(3'b000, 6'b000000, 1, 1, 5'd3, 5'd0, 5'd6, 32'd0, 32'd0, 32'd1, 32'd41, 1);
      check("fwd_ex_beats_wb", alu_src1, 32'd40);
      send(3'b000, 6'b000000, 1, 1, 5'd3, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'd100, 1);
      check("fwd_wb_src1", alu_src1, 32'd100);
      send(3'b010, 6'b100010, 0, 1, 5'd8, 5'd7, 5'd8, 32'd50, 32'd0, 32'd0, 32'hFFFF_FFCE, 1);
      check("fwd_ex_src2", alu_src2, 32'd100);
      wb_regwrite = 1'b0;
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd0, 32'd10, 32'd0, 32'd2, 32'd12, 1);
      wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'd99;
      send(3'b000, 6'b000000, 1, 1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd3, 32'd3, 1);
      check("fwd_r0_blocked", alu_src1, 32'd0);
      wb_regwrite = 1'b0;
      tick(3);

      // Backpressure: two instructions queued, third waits
      ex_ready = 1'b0;
      send(3'b000, 6'b000000, 1, 1, 5'd10, 5'd0, 5'd10, 32'd100, 32'd0, 32'd23, 32'd123, 1);
      send(3'b010, 6'b100100, 0, 1, 5'd12, 5'd13, 5'd11, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'h0000_00F0, 1);
      fork
         send(3'b010, 6'b101010, 0, 1, 5'd15, 5'd16, 5'd14, 32'd3, 32'd5, 32'd0, 32'd1, 1);
         begin
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("stall_id_ready", {31'd0, id_ready}, 32'd0);
               check("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
               check("stall_ex_result", ex_result, 32'd123);
               check("stall_src1", alu_src1, 32'h0000_F0F0);
               check("stall_src2", alu_src2, 32'h0000_0FF0);
               check("stall_ctrl", {28'd0, alu_ctrl}, 32'h0);
            end
            @(posedge clk);
            #1;
            ex_ready = 1'b1;
         end
      join
      tick(4);

      // Flush of a held instruction while stalled
      ex_ready = 1'b0;
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd18, 32'd50, 32'd0, 32'd5, 32'd55, 1);
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd19, 32'd1, 32'd0, 32'd1, 32'd2, 0);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("flush_id_ready", {31'd0, id_ready}, 32'd1);
      check("flush_ex_valid", {31'd0, ex_valid}, 32'd1);
      check("flush_ex_result", ex_result, 32'd55);
      ex_ready = 1'b1;
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd20, 32'd1, 32'd0, 32'd1, 32'd2, 1);
      tick(4);

      // Undefined funct: ADD fallback, sticky illegal
      check("illegal_before", {31'd0, illegal}, 32'd0);
      send(3'b010, 6'b111111, 0, 1, 5'd1, 5'd2, 5'd17, 32'd4, 32'd5, 32'd0, 32'd9, 1);
      check("illegal_ctrl", {28'd0, alu_ctrl}, 32'h2);
      tick(1);
      check("illegal_set", {31'd0, illegal}, 32'd1);
      tick(3);
      check("illegal_sticky", {31'd0, illegal}, 32'd1);

      // Reset mid-stream with a valid result held
      ex_ready = 1'b0;
      send(3'b000, 6'b000000, 1, 1, 5'd1, 5'd0, 5'd21, 32'd8, 32'd0, 32'd8, 32'd16, 1);
      tick(1);
      check("pre_rst_ex_valid", {31'd0, ex_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_ex_valid", {31'd0, ex_valid}, 32'd0);
      check("midrst_illegal",  {31'd0, illegal},  32'd0);
      check("midrst_id_ready", {31'd0, id_ready}, 32'd1);
      sb.delete();
      tick(1);
      rst = 1'b0;
      ex_ready = 1'b1;
      send(3'b010, 6'b100010, 0, 1, 5'd1, 5'd2, 5'd22, 32'd9, 32'd7, 32'd0, 32'd2, 1);
      tick(4);
      check("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_issue_stage
